// File: rtl/transmitter_pkg.sv
// Shared UART transmit definitions: command strobe bit positions, parity
// encodings, frame FSM state encodings and cell addressing helpers.
package transmitter_pkg;

   // Bit positions inside the one-hot action strobe
   localparam int ACT_WRITE     = 0;
   localparam int ACT_SEND_CELL = 1;
   localparam int ACT_SEND_ROW  = 2;
   localparam int ACT_SEND_ALL  = 3;

   // Parity selection values for the PAR parameter
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Frame FSM state encodings (kept as plain constants so the receiver can share them)
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Flat address of a matrix cell: row-major, row in the MSB
   typedef logic [2:0] cell_addr_t;

   function automatic cell_addr_t cell_addr(input logic row, input logic [1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/transmitter_if.sv
// Host-side bus of the UART transmitter: cell select, command strobe,
// write data, serial line, busy flag and matrix readback.
interface transmitter_if #(
   parameter int W = 8
);
   logic         row;
   logic [1:0]   col;
   logic [3:0]   action;
   logic [W-1:0] w_cell;
   logic         tx;
   logic         busy;
   logic [W-1:0] r_cell;

   modport master (
      output row, col, action, w_cell,
      input  tx, busy, r_cell
   );

   modport slave (
      input  row, col, action, w_cell,
      output tx, busy, r_cell
   );
endinterface

// File: rtl/transmitter_frame.sv
// Serialises one W-bit word as start / data (LSB first) / optional parity /
// stop, each bit held for DIV clocks. A load pulse starts a frame at once
// (tx drops to the start bit on that edge); last is high during the final
// cycle of the stop bit so the caller can chain the next word with no gap.
module transmitter_frame
   import transmitter_pkg::*;
#(
   parameter int W   = 8,
   parameter int DIV = 3,
   parameter int PAR = PAR_NONE
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] data,
   output logic         tx,
   output logic         last
);

   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW      = (W > 1) ? $clog2(W) : 1;
   localparam bit HAS_PAR = (PAR == PAR_EVEN) || (PAR == PAR_ODD);

   logic [2:0]    state;
   logic [DW-1:0] div_cnt;
   logic [BW-1:0] bit_idx;
   logic [W-1:0]  shreg;
   logic          par_q;
   logic          bit_end;

   assign bit_end = (div_cnt == DW'(DIV - 1));
   assign last    = (state == ST_STOP) && bit_end;

   // Bit timing, shifting and line level for one frame
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others, independent of statement order.
      if (rst) begin
         state   <= ST_IDLE;
         div_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         par_q   <= 1'b0;
         tx      <= 1'b1;
      end else if (load) begin
         state   <= ST_START;
         div_cnt <= '0;
         bit_idx <= '0;
         shreg   <= data;
         par_q   <= (PAR == PAR_ODD) ? ~^data : ^data;
         tx      <= 1'b0;
      end else if (state != ST_IDLE) begin
         if (!bit_end) begin
            div_cnt <= div_cnt + 1'b1;
         end else begin
            div_cnt <= '0;
            case (state)
               ST_START: begin
                  state <= ST_DATA;
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
               end
               ST_DATA: begin
                  if (bit_idx == BW'(W - 1)) begin
                     bit_idx <= '0;
                     if (HAS_PAR) begin
                        state <= ST_PARITY;
                        tx    <= par_q;
                     end else begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end
               ST_PARITY: begin
                  state <= ST_STOP;
                  tx    <= 1'b1;
               end
               default: begin
                  state <= ST_IDLE;
                  tx    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/transmitter.sv
// UART transmitter top: 2x4 matrix of W-bit cells, write/send command decode
// and burst sequencing. A burst sends one cell, one row or the whole matrix
// as back-to-back frames; each cell is read at its own frame start so writes
// to cells not yet sent still make it onto the line.
module transmitter
   import transmitter_pkg::*;
#(
   parameter int W   = 8,
   parameter int DIV = 3,
   parameter int PAR = PAR_NONE
) (
   input  logic          clk,
   input  logic          rst,
   transmitter_if.slave  bus
);

   logic [W-1:0] mem [8];

   logic       busy_q;
   cell_addr_t addr_q;
   logic [2:0] idx_q;
   logic [2:0] last_idx_q;

   logic       send_req;
   logic       accept;
   logic       next_cell;
   logic       frame_last;
   logic       load;
   cell_addr_t acc_addr;
   logic [2:0] acc_last;
   cell_addr_t load_addr;
   logic [W-1:0] load_data;
   logic       frame_tx;

   assign send_req  = |bus.action[ACT_SEND_ALL:ACT_SEND_CELL];
   assign accept    = !busy_q && send_req;
   assign next_cell = busy_q && frame_last && (idx_q != last_idx_q);
   assign load      = accept || next_cell;

   // Starting cell and burst length of a new send command, highest strobe wins
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      acc_addr = cell_addr(bus.row, bus.col);
      acc_last = 3'd0;
      if (bus.action[ACT_SEND_ALL]) begin
         acc_addr = cell_addr(1'b0, 2'd0);
         acc_last = 3'd7;
      end else if (bus.action[ACT_SEND_ROW]) begin
         acc_addr = cell_addr(bus.row, 2'd0);
         acc_last = 3'd3;
      end
   end

   // Word handed to the framer: read before any write landing on the same edge
   assign load_addr = accept ? acc_addr : cell_addr_t'(addr_q + 3'd1);
   assign load_data = mem[load_addr];

   // Matrix storage; host writes are accepted at any time, including mid-burst
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the matrix is only eight cells and must read back as zero after
      // reset, so it is built from resettable flops rather than a RAM macro.
      if (rst) begin
         for (int i = 0; i < 8; i++) mem[i] <= '0;
      end else if (bus.action[ACT_WRITE]) begin
         mem[cell_addr(bus.row, bus.col)] <= bus.w_cell;
      end
   end

   // Burst sequencing: accept a command, step through its cells, drop busy at the end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q     <= 1'b0;
         addr_q     <= '0;
         idx_q      <= '0;
         last_idx_q <= '0;
      end else if (accept) begin
         busy_q     <= 1'b1;
         addr_q     <= acc_addr;
         idx_q      <= '0;
         last_idx_q <= acc_last;
      end else if (next_cell) begin
         addr_q <= addr_q + 3'd1;
         idx_q  <= idx_q + 3'd1;
      end else if (busy_q && frame_last) begin
         busy_q <= 1'b0;
         idx_q  <= '0;
      end
   end

   transmitter_frame #(
      .W   (W),
      .DIV (DIV),
      .PAR (PAR)
   ) u_frame (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .data (load_data),
      .tx   (frame_tx),
      .last (frame_last)
   );

   assign bus.tx     = frame_tx;
   assign bus.busy   = busy_q;
   assign bus.r_cell = mem[cell_addr(bus.row, bus.col)];

endmodule

// File: tb/tb_transmitter.sv
// Bench for the UART transmitter: three instances (no, even, odd parity)
// share the same stimulus. A frame monitor decodes the PAR=0 line and pops
// the scoreboard of expected cells pushed when send commands are issued.
module tb_transmitter;

   localparam int W   = 8;
   localparam int DIV = 3;
   localparam int F0  = DIV * (W + 2);
   localparam int F1  = DIV * (W + 3);

   localparam logic [3:0] A_NONE = 4'b0000;
   localparam logic [3:0] A_WR   = 4'b0001;
   localparam logic [3:0] A_CELL = 4'b0010;
   localparam logic [3:0] A_ROW  = 4'b0100;
   localparam logic [3:0] A_ALL  = 4'b1000;

   typedef struct {
      logic       row;
      logic [1:0] col;
      logic [3:0] action;
      logic [7:0] w_cell;
      logic [7:0] exp_r;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   transmitter_if #(.W(W)) bus0 ();
   transmitter_if #(.W(W)) bus1 ();
   transmitter_if #(.W(W)) bus2 ();

   transmitter #(.W(W), .DIV(DIV), .PAR(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   transmitter #(.W(W), .DIV(DIV), .PAR(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   transmitter #(.W(W), .DIV(DIV), .PAR(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int n_checks = 0;
   int n_pass   = 0;
   int frames_seen = 0;
   logic [7:0] sb_q[$];
   logic [7:0] model[8];
   int unsigned bc0 = 0, bc1 = 0, bc2 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input logic r, input logic [1:0] c, input logic [3:0] a, input logic [7:0] d);
      bus0.row = r; bus0.col = c; bus0.action = a; bus0.w_cell = d;
      bus1.row = r; bus1.col = c; bus1.action = a; bus1.w_cell = d;
      bus2.row = r; bus2.col = c; bus2.action = a; bus2.w_cell = d;
   endtask

   // Called at a negedge; returns at the next negedge with the strobe cleared
   task automatic do_cmd(input logic r, input logic [1:0] c, input logic [3:0] a, input logic [7:0] d);
      drive(r, c, a, d);
      @(posedge clk);
      if (a[0]) model[{r, c}] = d;
      @(negedge clk);
      drive(r, c, A_NONE, d);
   endtask

   // Send from idle: queue the expected cells (pre-write contents) then issue
   task automatic send(input logic r, input logic [1:0] c, input logic [3:0] a, input logic [7:0] d);
      if (a[3]) begin
         for (int i = 0; i < 8; i++) sb_q.push_back(model[i]);
      end else if (a[2]) begin
         for (int i = 0; i < 4; i++) sb_q.push_back(model[{r, 2'(i)}]);
      end else if (a[1]) begin
         sb_q.push_back(model[{r, c}]);
      end
      do_cmd(r, c, a, d);
   endtask

   task automatic wait_idle(input string tag);
      bit fell = 1'b0;
      bit done = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clk);
         if (!fell && bus0.busy === 1'b0) begin
            fell = 1'b1;
            check({tag, " tx at busy fall"}, 32'(bus0.tx), 1);
         end
         if (bus0.busy === 1'b0 && bus1.busy === 1'b0 && bus2.busy === 1'b0) done = 1'b1;
      end
      check({tag, " idle reached"}, 32'(done), 1);
   endtask

   // Busy-cycle counters, sampled mid-cycle
   always @(negedge clk) begin
      if (bus0.busy === 1'b1) bc0 <= bc0 + 1;
      if (bus1.busy === 1'b1) bc1 <= bc1 + 1;
      if (bus2.busy === 1'b1) bc2 <= bc2 + 1;
   end

   // Frame monitor on the PAR=0 line: every bit must hold for exactly DIV samples
   initial begin
      logic [9:0] lvl;
      bit ok, abort;
      logic s;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0 || bus0.tx !== 1'b0) continue;
         ok = 1'b1;
         abort = 1'b0;
         lvl = '0;
         for (int k = 0; k < F0; k++) begin
            if (k > 0) @(negedge clk);
            if (rst !== 1'b0) begin
               abort = 1'b1;
               break;
            end
            s = bus0.tx;
            if (k % DIV == 0) lvl[k / DIV] = s;
            else if (s !== lvl[k / DIV]) ok = 1'b0;
         end
         if (!abort) begin
            frames_seen++;
            check("frame shape {stable,start,stop}", {29'd0, ok, lvl[0], lvl[9]}, 32'b101);
            check("frame expected by scoreboard", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) check("frame data", 32'(lvl[8:1]), 32'(sb_q.pop_front()));
         end
      end
   end

   initial begin
      vec_t vecs[10];
      int unsigned s0, s1, s2;
      int fs;

      vecs[0] = '{row: 1'b0, col: 2'd0, action: A_WR,   w_cell: 8'h3C, exp_r: 8'h3C};
      vecs[1] = '{row: 1'b0, col: 2'd1, action: A_WR,   w_cell: 8'hA5, exp_r: 8'hA5};
      vecs[2] = '{row: 1'b0, col: 2'd2, action: A_WR,   w_cell: 8'h5A, exp_r: 8'h5A};
      vecs[3] = '{row: 1'b0, col: 2'd3, action: A_WR,   w_cell: 8'h81, exp_r: 8'h81};
      vecs[4] = '{row: 1'b1, col: 2'd0, action: A_WR,   w_cell: 8'h11, exp_r: 8'h11};
      vecs[5] = '{row: 1'b1, col: 2'd1, action: A_WR,   w_cell: 8'h22, exp_r: 8'h22};
      vecs[6] = '{row: 1'b1, col: 2'd2, action: A_WR,   w_cell: 8'h33, exp_r: 8'h33};
      vecs[7] = '{row: 1'b1, col: 2'd3, action: A_WR,   w_cell: 8'h44, exp_r: 8'h44};
      vecs[8] = '{row: 1'b0, col: 2'd1, action: A_NONE, w_cell: 8'hEE, exp_r: 8'hA5};
      vecs[9] = '{row: 1'b1, col: 2'd2, action: A_NONE, w_cell: 8'h00, exp_r: 8'h33};

      for (int i = 0; i < 8; i++) model[i] = '0;
      rst = 1'b0;
      drive(1'b0, 2'd0, A_NONE, 8'h00);
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset tx", 32'(bus0.tx), 1);
      check("reset busy", 32'(bus0.busy), 0);
      check("reset r_cell", 32'(bus0.r_cell), 0);
      rst = 1'b0;
      @(negedge clk);

      // Write / readback table
      for (int i = 0; i < 10; i++) begin
         do_cmd(vecs[i].row, vecs[i].col, vecs[i].action, vecs[i].w_cell);
         check($sformatf("table %0d r_cell", i), 32'(bus0.r_cell), 32'(vecs[i].exp_r));
      end

      // Single cell 0xA5 from [0][1]
      s0 = bc0; fs = frames_seen;
      send(1'b0, 2'd1, A_CELL, 8'h00);
      check("cell start bit", 32'(bus0.tx), 0);
      check("cell busy", 32'(bus0.busy), 1);
      wait_idle("cell");
      check("cell busy cycles", bc0 - s0, F0);
      check("cell frames", 32'(frames_seen - fs), 1);

      // Row 1: four back-to-back frames
      s0 = bc0; fs = frames_seen;
      send(1'b1, 2'd0, A_ROW, 8'h00);
      wait_idle("row");
      check("row busy cycles", bc0 - s0, 4 * F0);
      check("row frames", 32'(frames_seen - fs), 4);
      check("row scoreboard drained", 32'(sb_q.size()), 0);

      // Whole matrix, with a write to [1][3] before it goes out and an ignored send pulse
      s0 = bc0; fs = frames_seen;
      send(1'b0, 2'd0, A_ALL, 8'h00);
      repeat (50) @(negedge clk);
      do_cmd(1'b1, 2'd3, A_WR, 8'hFF);
      sb_q[sb_q.size() - 1] = 8'hFF;
      check("write while busy r_cell", 32'(bus0.r_cell), 32'hFF);
      repeat (40) @(negedge clk);
      do_cmd(1'b0, 2'd0, A_CELL, 8'h00);
      wait_idle("all");
      check("all busy cycles", bc0 - s0, 8 * F0);
      check("all frames", 32'(frames_seen - fs), 8);
      check("all scoreboard drained", 32'(sb_q.size()), 0);

      // Write and send of the same cell on one edge: old contents go out
      s0 = bc0;
      send(1'b0, 2'd2, A_CELL | A_WR, 8'h99);
      wait_idle("coincident");
      check("coincident r_cell", 32'(bus0.r_cell), 32'h99);
      check("coincident busy cycles", bc0 - s0, F0);

      // Parity: 0x07 has three ones
      do_cmd(1'b0, 2'd0, A_WR, 8'h07);
      s0 = bc0; s1 = bc1; s2 = bc2;
      send(1'b0, 2'd0, A_CELL, 8'h00);
      repeat (28) @(negedge clk);
      check("even parity bit", 32'(bus1.tx), 1);
      check("odd parity bit", 32'(bus2.tx), 0);
      check("no-parity stop bit", 32'(bus0.tx), 1);
      wait_idle("parity");
      check("even busy cycles", bc1 - s1, F1);
      check("odd busy cycles", bc2 - s2, F1);
      check("no-parity busy cycles", bc0 - s0, F0);

      // Reset in the middle of a data bit
      send(1'b1, 2'd1, A_CELL, 8'h00);
      repeat (12) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid-frame reset tx", 32'(bus0.tx), 1);
      check("mid-frame reset busy", 32'(bus0.busy), 0);
      check("mid-frame reset r_cell", 32'(bus0.r_cell), 0);
      sb_q.delete();
      for (int i = 0; i < 8; i++) model[i] = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_cmd(1'b1, 2'd1, A_WR, 8'hC3);
      s0 = bc0; fs = frames_seen;
      send(1'b1, 2'd1, A_CELL, 8'h00);
      wait_idle("post-reset");
      check("post-reset busy cycles", bc0 - s0, F0);
      check("post-reset frames", 32'(frames_seen - fs), 1);

      repeat (5) @(negedge clk);
      check("final scoreboard drained", 32'(sb_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
